// File: rtl/fft_bfly_pair_buffer.sv
// Radix-2 butterfly input stage: buffers the first half of each 2*DEPTH span
// and presents (x[k], x[k+DEPTH]) pairs with index k as second-half samples arrive.
`ifndef FFT_DATA_WIDTH
`define FFT_DATA_WIDTH 16
`endif

package fft_bfly_pair_buffer_pkg;
    localparam int unsigned FFT_DATA_WIDTH = `FFT_DATA_WIDTH;

    typedef struct packed {
        logic signed [FFT_DATA_WIDTH-1:0] data_r;
        logic signed [FFT_DATA_WIDTH-1:0] data_i;
    } fft_data_sample_t;
endpackage

module fft_bfly_pair_buffer
    import fft_bfly_pair_buffer_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned CW    = $clog2(2*DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  fft_data_sample_t in_data,
    output fft_data_sample_t opa,
    output fft_data_sample_t opb,
    output logic             pair_valid,
    output logic [CW-2:0]    pair_idx,
    output logic             pair_last,
    output logic             sync_err
);
    localparam int unsigned AW = CW - 1;

    logic [CW-1:0]    cnt_q, cnt_d;
    fft_data_sample_t opa_q, opa_d;
    fft_data_sample_t opb_q, opb_d;
    logic             pair_valid_q, pair_valid_d;
    logic [AW-1:0]    pair_idx_q, pair_idx_d;
    logic             pair_last_q, pair_last_d;
    logic             sync_err_q, sync_err_d;

    fft_data_sample_t mem_q [DEPTH];
    logic             mem_we;
    logic [AW-1:0]    mem_wa;

    logic             phase;
    logic [AW-1:0]    addr;

    assign phase = cnt_q[CW-1];
    assign addr  = cnt_q[AW-1:0];

    // Next-state: sof forces index 0 (discarding any partial span), else FILL writes / PAIR emits.
    always_comb begin
        cnt_d        = cnt_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        pair_valid_d = 1'b0;
        pair_idx_d   = pair_idx_q;
        pair_last_d  = 1'b0;
        sync_err_d   = sync_err_q;
        mem_we       = 1'b0;
        mem_wa       = addr;

        if (in_valid) begin
            if (in_sof) begin
                cnt_d  = CW'(1);
                mem_we = 1'b1;
                mem_wa = '0;
                if (cnt_q != '0) begin
                    sync_err_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
                if (!phase) begin
                    mem_we = 1'b1;
                end else begin
                    opa_d        = mem_q[addr];
                    opb_d        = in_data;
                    pair_valid_d = 1'b1;
                    pair_idx_d   = addr;
                    pair_last_d  = (addr == AW'(DEPTH - 1));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            pair_valid_q <= 1'b0;
            pair_idx_q   <= '0;
            pair_last_q  <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            pair_valid_q <= pair_valid_d;
            pair_idx_q   <= pair_idx_d;
            pair_last_q  <= pair_last_d;
            sync_err_q   <= sync_err_d;
        end
    end

    // First-half storage; contents are always rewritten before being read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= in_data;
        end
    end

    assign opa        = opa_q;
    assign opb        = opb_q;
    assign pair_valid = pair_valid_q;
    assign pair_idx   = pair_idx_q;
    assign pair_last  = pair_last_q;
    assign sync_err   = sync_err_q;
endmodule

// File: tb/tb_fft_bfly_pair_buffer.sv
// Self-checking bench for fft_bfly_pair_buffer (DEPTH=4): a hand-written vector
// table for the basic frame, then scoreboard-checked streams for the corner cases.
module tb_fft_bfly_pair_buffer;
    import fft_bfly_pair_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(2*DEPTH);
    localparam int unsigned W     = FFT_DATA_WIDTH;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_sof;
    fft_data_sample_t in_data;
    fft_data_sample_t opa;
    fft_data_sample_t opb;
    logic             pair_valid;
    logic [CW-2:0]    pair_idx;
    logic             pair_last;
    logic             sync_err;

    fft_bfly_pair_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .opa        (opa),
        .opb        (opb),
        .pair_valid (pair_valid),
        .pair_idx   (pair_idx),
        .pair_last  (pair_last),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic fft_data_sample_t mk(input int r, input int i);
        fft_data_sample_t s;
        s.data_r = W'(r);
        s.data_i = W'(i);
        return s;
    endfunction

    // Vector table for the basic frame: inputs for one cycle, outputs seen after that edge.
    typedef struct {
        logic v;
        logic sof;
        int   dr;
        logic exp_pv;
        int   exp_a;
        int   exp_b;
        int   exp_idx;
        logic exp_last;
    } vec_t;

    // Scoreboard entry for one expected pair.
    typedef struct {
        fft_data_sample_t a;
        fft_data_sample_t b;
        int               idx;
        logic             last;
    } pair_t;

    pair_t            sb_q[$];
    int               m_cnt;
    fft_data_sample_t m_buf [DEPTH];
    logic             m_err;

    function automatic void model_reset();
        m_cnt = 0;
        m_err = 1'b0;
        sb_q.delete();
    endfunction

    // Drive one cycle, advance the reference model, then compare after the edge.
    task automatic step(input logic v, input logic sof, input fft_data_sample_t d);
        logic  exp_pv;
        pair_t p;
        exp_pv   = 1'b0;
        in_valid = v;
        in_sof   = sof;
        in_data  = d;
        if (v) begin
            if (sof) begin
                if (m_cnt != 0) m_err = 1'b1;
                m_buf[0] = d;
                m_cnt    = 1;
            end else begin
                if (m_cnt < int'(DEPTH)) begin
                    m_buf[m_cnt] = d;
                end else begin
                    p.a    = m_buf[m_cnt - int'(DEPTH)];
                    p.b    = d;
                    p.idx  = m_cnt - int'(DEPTH);
                    p.last = (p.idx == int'(DEPTH) - 1);
                    sb_q.push_back(p);
                    exp_pv = 1'b1;
                end
                m_cnt = (m_cnt + 1) % (2 * int'(DEPTH));
            end
        end
        @(posedge clk);
        #1;
        check("pair_valid", 64'(pair_valid), 64'(exp_pv));
        if (exp_pv && pair_valid && sb_q.size() > 0) begin
            p = sb_q.pop_front();
            check("opa", 64'(opa), 64'(p.a));
            check("opb", 64'(opb), 64'(p.b));
            check("pair_idx", 64'(pair_idx), 64'(p.idx));
            check("pair_last", 64'(pair_last), 64'(p.last));
        end
        check("sync_err", 64'(sync_err), 64'(m_err));
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    vec_t vt [10];

    initial begin
        int   pairs_seen;
        int   lasts_at [$];
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        model_reset();

        vt[0] = '{1, 1, 0, 0, 0, 0, 0, 0};
        vt[1] = '{1, 0, 1, 0, 0, 0, 0, 0};
        vt[2] = '{1, 0, 2, 0, 0, 0, 0, 0};
        vt[3] = '{1, 0, 3, 0, 0, 0, 0, 0};
        vt[4] = '{1, 0, 4, 1, 0, 4, 0, 0};
        vt[5] = '{1, 0, 5, 1, 1, 5, 1, 0};
        vt[6] = '{1, 0, 6, 1, 2, 6, 2, 0};
        vt[7] = '{1, 0, 7, 1, 3, 7, 3, 1};
        vt[8] = '{0, 0, 0, 0, 3, 7, 3, 0};
        vt[9] = '{0, 0, 0, 0, 3, 7, 3, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pair_valid", 64'(pair_valid), 64'd0);
        check("rst_opa", 64'(opa), 64'd0);
        check("rst_opb", 64'(opb), 64'd0);
        check("rst_pair_idx", 64'(pair_idx), 64'd0);
        check("rst_pair_last", 64'(pair_last), 64'd0);
        check("rst_sync_err", 64'(sync_err), 64'd0);
        do_reset();

        // Basic frame from the vector table; data_i = -data_r throughout
        for (int n = 0; n < 10; n++) begin
            in_valid = vt[n].v;
            in_sof   = vt[n].sof;
            in_data  = mk(vt[n].dr, -vt[n].dr);
            @(posedge clk);
            #1;
            check("tbl_pair_valid", 64'(pair_valid), 64'(vt[n].exp_pv));
            check("tbl_opa", 64'(opa), 64'(mk(vt[n].exp_a, -vt[n].exp_a)));
            check("tbl_opb", 64'(opb), 64'(mk(vt[n].exp_b, -vt[n].exp_b)));
            check("tbl_pair_idx", 64'(pair_idx), 64'(vt[n].exp_idx));
            check("tbl_pair_last", 64'(pair_last), 64'(vt[n].exp_last));
            check("tbl_sync_err", 64'(sync_err), 64'd0);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;

        // Gaps: 3 idle cycles between halves, random idles during PAIR
        do_reset();
        for (int n = 0; n < 8; n++) begin
            if (n == 4) repeat (3) step(1'b0, 1'b0, mk(99, 99));
            if (n > 4) repeat ($urandom_range(0, 2)) step(1'b0, 1'b1, mk(55, 55));
            step(1'b1, n == 0, mk(n, -n));
        end
        check("gap_sb_empty", 64'(sb_q.size()), 64'd0);

        // Three spans back to back; pair_last on pairs 4, 8, 12
        do_reset();
        pairs_seen = 0;
        for (int n = 0; n < 24; n++) begin
            step(1'b1, n == 0, mk(1000 + n, -(1000 + n)));
            if (pair_valid) begin
                pairs_seen++;
                if (pair_last) lasts_at.push_back(pairs_seen);
            end
        end
        check("b2b_pairs", 64'(pairs_seen), 64'd12);
        check("b2b_nlast", 64'(lasts_at.size()), 64'd3);
        if (lasts_at.size() == 3) begin
            check("b2b_last0", 64'(lasts_at[0]), 64'd4);
            check("b2b_last1", 64'(lasts_at[1]), 64'd8);
            check("b2b_last2", 64'(lasts_at[2]), 64'd12);
        end

        // Misaligned sof at n=2 restarts the span and sets sticky sync_err
        do_reset();
        step(1'b1, 1'b1, mk(10, 0));
        step(1'b1, 1'b0, mk(11, 0));
        for (int n = 0; n < 8; n++) step(1'b1, n == 0, mk(100 + n, 0));
        step(1'b0, 1'b0, mk(0, 0));
        step(1'b1, 1'b1, mk(7, 7));
        check("sof_err_sticky", 64'(sync_err), 64'd1);
        // A PAIR-phase sof also discards the partial span
        for (int n = 1; n < 6; n++) step(1'b1, 1'b0, mk(7 + n, 7));
        step(1'b1, 1'b1, mk(200, 0));
        for (int n = 1; n < 8; n++) step(1'b1, 1'b0, mk(200 + n, 0));

        // Asynchronous reset mid-cycle after n=5
        do_reset();
        for (int n = 0; n < 6; n++) step(1'b1, n == 0, mk(300 + n, 1));
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_pair_valid", 64'(pair_valid), 64'd0);
        check("arst_opa", 64'(opa), 64'd0);
        check("arst_opb", 64'(opb), 64'd0);
        check("arst_sync_err", 64'(sync_err), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("arst_no_stale", 64'(pair_valid), 64'd0);
        for (int n = 0; n < 8; n++) step(1'b1, n == 0, mk(400 + n, -n));
        step(1'b0, 1'b0, mk(0, 0));

        // Full-scale values in both halves
        for (int n = 0; n < 8; n++) begin
            if (n[0]) step(1'b1, n == 0, mk(-(1 << (W - 1)), (1 << (W - 1)) - 1));
            else      step(1'b1, n == 0, mk((1 << (W - 1)) - 1, -(1 << (W - 1))));
        end
        step(1'b0, 1'b0, mk(0, 0));
        check("end_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fft_bfly_pair_buffer.md
Name: fft_bfly_pair_buffer

Overview:
Streaming input stage for the radix-2 butterfly. Accepts one complex sample per valid cycle and holds the first half of each 2*DEPTH-sample span. When the matching second-half sample arrives, it presents the pair (x[k], x[k+DEPTH]) on opa/opb to the downstream complex adder and subtractor. It also emits the butterfly index k, which the twiddle-address logic uses.

Parameters:
DEPTH, 8, butterfly span; samples k and k+DEPTH are paired; power of 2, >= 2
CW, $clog2(2*DEPTH), width of the internal sample counter (derived; do not override)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data holds a sample this cycle
in_sof  input  1  start of frame; qualified by in_valid; marks sample index 0
in_data  input  FFT_DATA_SAMPLE  complex sample (data_r, data_i, each `FFT_DATA_WIDTH bits, signed)
opa  output  FFT_DATA_SAMPLE  first-half sample x[k]; feeds csub/cadd opa
opb  output  FFT_DATA_SAMPLE  second-half sample x[k+DEPTH]; feeds csub/cadd opb
pair_valid  output  1  opa/opb/pair_idx valid this cycle
pair_idx  output  CW-1  butterfly index k, 0..DEPTH-1
pair_last  output  1  asserted with pair_valid when k == DEPTH-1
sync_err  output  1  sticky; set on a misaligned in_sof

Behaviour:
- Reset (async, rst_n=0): cnt=0; opa=0, opb=0, pair_valid=0, pair_idx=0, pair_last=0, sync_err=0. Buffer contents are don't-care and are never read before being rewritten.
- Counter cnt[CW-1:0] advances by 1 only on cycles with in_valid=1, wrapping from 2*DEPTH-1 to 0. Phase = cnt[CW-1]: 0 = FILL, 1 = PAIR. Address a = cnt[CW-2:0].
- FILL, in_valid=1: buf[a] <= in_data. No output is produced.
- PAIR, in_valid=1: on the next edge, opa <= buf[a], opb <= in_data, pair_idx <= a, pair_valid <= 1, pair_last <= (a == DEPTH-1).
- Latency: outputs register one clock after the second-half sample is accepted. Throughput is one pair per PAIR-phase input.
- pair_valid is a single-cycle pulse per pair. On cycles with no pair, pair_valid=0 and opa/opb/pair_idx hold their last values. No backpressure; the downstream stage (latency 2, fully pipelined) always accepts.
- in_valid=0: no state change; the counter and buffer are frozen, so gaps are allowed anywhere in the stream, including between the halves.
- in_sof=1 with in_valid=1: the sample is treated as index 0 (written to buf[0], and cnt becomes 1 after the edge), whatever the current cnt.
  - If cnt != 0 at that moment, sync_err <= 1 and the partial span is discarded. No pair is emitted for the discarded first-half entries.
- sync_err is cleared only by reset.
- in_sof with in_valid=0 is ignored.
- Wrap: the last PAIR sample (cnt=2*DEPTH-1) produces pair_last; the next valid sample re-enters FILL at a=0. No idle cycle is needed between spans.
- Reset mid-span: all progress is lost; the stream restarts at index 0 after rst_n deasserts. No pair_valid pulse is generated from pre-reset data.
- Data passes bit-exact: no arithmetic, rounding or saturation in this block.
- Storage: DEPTH x (2*`FFT_DATA_WIDTH) registers or a 1R1W array. A read of buf[a] and the write of the same address in a later span never occur in the same cycle.

Test Plan:
- DEPTH=4, reset, then 8 consecutive valid samples with data_r=n, data_i=-n for n=0..7 and sof on n=0 -> 4 pulses on cycles 6..9 after the first sample: (opa,opb) = (0,4),(1,5),(2,6),(3,7), pair_idx 0..3, pair_last only on the 4th pulse, sync_err=0.
- Same stream with in_valid deasserted for 3 cycles between n=3 and n=4, and randomly toggled during PAIR -> identical pair values and order; each pulse exactly 1 cycle after its opb sample.
- 24 back-to-back samples (3 spans) without idle -> 12 pairs, pair_last at pairs 4, 8, 12; the first span's data never appears in later spans.
- Valid sof at n=2 of a span, then 8 samples 100..107 -> no pair for the discarded samples, sync_err=1 and sticky; pairs (100,104)..(103,107).
- Assert rst_n=0 asynchronously (mid-cycle) after n=5 -> pair_valid, opa, opb drop to 0 immediately. A fresh 8-sample frame then produces 4 correct pairs and sync_err=0.
- Full-scale values: data_r = 2^(W-1)-1 and -2^(W-1) in both halves -> opa/opb bit-exact, no sign extension or truncation artefacts.
